// File: rtl/gic_slave_if.sv
// GIC link lanes and Wishbone classic master bus of gic_slave, named from the slave's point of view.
interface gic_slave_if;
    logic        gic_cs_i;
    logic [3:0]  gic_dat_i;
    logic [3:0]  gic_dat_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport slave (
        input  gic_cs_i, gic_dat_i, wb_dat_i, wb_ack_i, wb_err_i,
        output gic_dat_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
               wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );

    modport master (
        output gic_cs_i, gic_dat_i, wb_dat_i, wb_ack_i, wb_err_i,
        input  gic_dat_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
               wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );
endinterface

// File: rtl/gic_slave.sv
// GIC link slave: turns one nibble-serial request frame into a single Wishbone classic cycle and returns status/read data.
// Optional bus timeout is enabled by defining GIC_SLAVE_TIMEOUT_EN.
module gic_slave #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic        wb_clk_i,
    input logic        wb_rstn_i,
    gic_slave_if.slave bus
);
    localparam int unsigned DataW = 32;
    localparam int unsigned NibW  = 4;
    localparam int unsigned SelW  = 4;
    localparam int unsigned CntW  = 3;
    localparam int unsigned TmoW  = 16;
    localparam logic [NibW-1:0] StatOk  = 4'hA;
    localparam logic [NibW-1:0] StatErr = 4'hE;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("gic_slave: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADR, S_SEL, S_WDAT, S_BUS, S_STAT, S_RDAT, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              bad_q, bad_d;
    logic              abort_q, abort_d;
    logic [DataW-1:0]  adr_q, adr_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [DataW-1:0]  wdat_q, wdat_d;
    logic [DataW-1:0]  rdat_q, rdat_d;
    logic              cyc_q, cyc_d;
    logic [NibW-1:0]   gdat_q, gdat_d;
    logic              tmo_hit_c;
    logic              bus_done_c;

    assign bus_done_c = bus.wb_ack_i | bus.wb_err_i | tmo_hit_c;

`ifdef GIC_SLAVE_TIMEOUT_EN
    logic [TmoW-1:0] tmo_q, tmo_d;

    // Counter sits at zero outside BUS, so it is clear on every BUS entry.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_BUS) tmo_d = tmo_q + TmoW'(1);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) tmo_q <= '0;
        else            tmo_q <= tmo_d;
    end

    assign tmo_hit_c = (state_q == S_BUS) && !(bus.wb_ack_i || bus.wb_err_i) &&
                       (tmo_q + TmoW'(1) == TmoW'(TIMEOUT_CYCLES));
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Next-state and output decode; the return lane idles at the 0 "wait" code.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        bad_d   = bad_q;
        abort_d = abort_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        cyc_d   = cyc_q;
        gdat_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.gic_cs_i) begin
                    we_d    = bus.gic_dat_i[0];
                    bad_d   = |bus.gic_dat_i[3:1];
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ADR;
                end
            end
            S_ADR: begin
                if (!bus.gic_cs_i) begin
                    state_d = S_IDLE;
                end else begin
                    adr_d = {adr_q[DataW-NibW-1:0], bus.gic_dat_i};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(7)) state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (!bus.gic_cs_i) begin
                    state_d = S_IDLE;
                end else begin
                    sel_d = bus.gic_dat_i;
                    cnt_d = '0;
                    // A bad header is treated as a read-length frame and answered without a bus cycle.
                    if (bad_q) begin
                        state_d = S_STAT;
                        gdat_d  = StatErr;
                    end else if (we_q) begin
                        state_d = S_WDAT;
                    end else begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end
            S_WDAT: begin
                if (!bus.gic_cs_i) begin
                    state_d = S_IDLE;
                end else begin
                    wdat_d = {wdat_q[DataW-NibW-1:0], bus.gic_dat_i};
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(7)) begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end
            S_BUS: begin
                abort_d = abort_q | ~bus.gic_cs_i;
                if (bus_done_c) begin
                    cyc_d  = 1'b0;
                    rdat_d = (bus.wb_ack_i | bus.wb_err_i) ? bus.wb_dat_i : '0;
                    // A frame abandoned mid-cycle still finishes the cycle, then drops the response.
                    if (abort_q || !bus.gic_cs_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STAT;
                        gdat_d  = (bus.wb_err_i || tmo_hit_c) ? StatErr : StatOk;
                    end
                end
            end
            S_STAT: begin
                if (!bus.gic_cs_i) begin
                    state_d = S_IDLE;
                end else if (!we_q && !bad_q) begin
                    gdat_d  = rdat_q[DataW-1 -: NibW];
                    rdat_d  = {rdat_q[DataW-NibW-1:0], NibW'(0)};
                    cnt_d   = '0;
                    state_d = S_RDAT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_RDAT: begin
                if (!bus.gic_cs_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CntW'(7)) begin
                    state_d = S_DONE;
                end else begin
                    gdat_d = rdat_q[DataW-1 -: NibW];
                    rdat_d = {rdat_q[DataW-NibW-1:0], NibW'(0)};
                    cnt_d  = cnt_q + CntW'(1);
                end
            end
            S_DONE: begin
                if (!bus.gic_cs_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            abort_q <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            cyc_q   <= 1'b0;
            gdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            abort_q <= abort_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            cyc_q   <= cyc_d;
            gdat_q  <= gdat_d;
        end
    end

    assign bus.gic_dat_o = gdat_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = wdat_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = cyc_q;
    assign bus.wb_cti_o  = 3'b000;
    assign bus.wb_bte_o  = 2'b00;
endmodule

// File: tb/tb_gic_slave.sv
// Scoreboard bench for gic_slave: directed GIC frames, a Wishbone slave model, and decoupled
// monitors for the return lane and the Wishbone request.
module tb_gic_slave;
    localparam int unsigned TmoCycles = 16;

    typedef struct {
        logic [3:0]  stat;
        bit          rd;
        logic [31:0] rdata;
        int          off;
    } rsp_t;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        int          off;
    } wbx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gic_slave_if bus();

    gic_slave #(.TIMEOUT_CYCLES(TmoCycles)) dut (
        .wb_clk_i (clk),
        .wb_rstn_i(rst_n),
        .bus      (bus.slave)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc_n = 0;
    int frame_start = 0;
    int rsp_cnt = 0;
    int rsp_target = 0;
    rsp_t rsp_q[$];
    wbx_t wb_q[$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    // Wishbone slave model: answers after wb_wait cycles; mode 0 ack, 1 err, 2 ack+err, 3 never.
    int wb_wait = 0;
    int wb_mode = 0;
    int wait_cnt = 0;
    logic [31:0] wb_rdata = 32'h0;
    always @(negedge clk) begin
        bus.wb_dat_i = wb_rdata;
        if (bus.wb_cyc_o && bus.wb_stb_o && wb_mode != 3 && wait_cnt >= wb_wait) begin
            bus.wb_ack_i = (wb_mode == 0 || wb_mode == 2);
            bus.wb_err_i = (wb_mode == 1 || wb_mode == 2);
        end else begin
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
        end
        if (bus.wb_cyc_o && bus.wb_stb_o) wait_cnt++;
        else wait_cnt = 0;
    end

    // Wishbone request monitor
    int   wb_starts = 0;
    int   cyc_len = 0;
    int   last_len = 0;
    logic cyc_prev = 1'b0;
    wbx_t wx;
    always @(negedge clk) begin
        if (bus.wb_cyc_o) cyc_len++;
        if (bus.wb_cyc_o && !cyc_prev) begin
            wb_starts++;
            if (wb_q.size() == 0) begin
                chk("unexpected_wb_cycle", 32'(bus.wb_cyc_o), 32'h0);
            end else begin
                wx = wb_q.pop_front();
                chk("wb_adr", bus.wb_adr_o, wx.adr);
                chk("wb_sel", 32'(bus.wb_sel_o), 32'(wx.sel));
                chk("wb_we", 32'(bus.wb_we_o), 32'(wx.we));
                if (wx.we) chk("wb_dat", bus.wb_dat_o, wx.dat);
                chk("wb_stb", 32'(bus.wb_stb_o), 32'h1);
                chk("wb_cti_bte", {27'h0, bus.wb_cti_o, bus.wb_bte_o}, 32'h0);
                chk("wb_start_cycle", 32'(cyc_n - frame_start), 32'(wx.off));
            end
        end
        if (!bus.wb_cyc_o && cyc_prev) begin
            last_len = cyc_len;
            cyc_len  = 0;
        end
        cyc_prev = bus.wb_cyc_o;
    end

    // Return-lane monitor: status, optional 8 read nibbles, then the wait code again.
    int          mstate = 0;
    int          nib = 0;
    logic [31:0] acc = 32'h0;
    rsp_t        cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            mstate = 0;
        end else begin
            case (mstate)
                0: if (bus.gic_dat_o != 4'h0) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_status", 32'(bus.gic_dat_o), 32'h0);
                    end else begin
                        cur = rsp_q.pop_front();
                        chk("status", 32'(bus.gic_dat_o), 32'(cur.stat));
                        if (cur.off >= 0) chk("status_cycle", 32'(cyc_n - frame_start), 32'(cur.off));
                        acc    = 32'h0;
                        nib    = 0;
                        mstate = cur.rd ? 1 : 2;
                    end
                end
                1: begin
                    acc = {acc[27:0], bus.gic_dat_o};
                    nib++;
                    if (nib == 8) begin
                        chk("read_data", acc, cur.rdata);
                        mstate = 2;
                    end
                end
                default: begin
                    chk("trailing_wait_code", 32'(bus.gic_dat_o), 32'h0);
                    rsp_cnt++;
                    mstate = 0;
                end
            endcase
        end
    end

    task automatic send_nibbles(input logic [3:0] hdr, input logic [31:0] adr, input logic [3:0] sel,
                                input logic [31:0] wdat, input int n, input bit drop);
        logic [3:0] nibs [18];
        nibs[0] = hdr;
        nibs[9] = sel;
        for (int i = 0; i < 8; i++) begin
            nibs[1+i]  = adr[31-4*i -: 4];
            nibs[10+i] = wdat[31-4*i -: 4];
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) frame_start = cyc_n;
            bus.gic_cs_i  = 1'b1;
            bus.gic_dat_i = nibs[i];
        end
        @(posedge clk); #1;
        bus.gic_cs_i  = !drop;
        bus.gic_dat_i = 4'h0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            bus.gic_cs_i  = 1'b0;
            bus.gic_dat_i = 4'h0;
        end
    endtask

    task automatic wait_rsp(input int target);
        int g = 0;
        while (rsp_cnt < target && g < 3000) begin
            @(posedge clk);
            g++;
        end
        chk("response_arrived", 32'(rsp_cnt >= target), 32'h1);
    endtask

    task automatic run_frame(input logic [3:0] hdr, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] wdat);
        send_nibbles(hdr, adr, sel, wdat, (hdr == 4'h1) ? 18 : 10, 1'b0);
        rsp_target++;
        wait_rsp(rsp_target);
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int starts;
    int hi;
    initial begin
        bus.gic_cs_i  = 1'b0;
        bus.gic_dat_i = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gic_dat", 32'(bus.gic_dat_o), 32'h0);
        chk("rst_wb_adr", bus.wb_adr_o, 32'h0);
        chk("rst_wb_dat", bus.wb_dat_o, 32'h0);
        chk("rst_ctrl", {26'h0, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o}, 32'h0);
        chk("rst_stb", 32'(bus.wb_stb_o), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Zero-wait write
        wb_mode = 0; wb_wait = 0; wb_rdata = 32'h0;
        wb_q.push_back('{32'h9100_0010, 4'hF, 1'b1, 32'hDEAD_BEEF, 18});
        rsp_q.push_back('{4'hA, 1'b0, 32'h0, 19});
        run_frame(4'h1, 32'h9100_0010, 4'hF, 32'hDEAD_BEEF);

        // Read with three wait states
        wb_wait = 3; wb_rdata = 32'h1234_5678;
        wb_q.push_back('{32'h0000_0100, 4'hF, 1'b0, 32'h0, 10});
        rsp_q.push_back('{4'hA, 1'b1, 32'h1234_5678, 14});
        run_frame(4'h0, 32'h0000_0100, 4'hF, 32'h0);

        // ack and err together: err wins, captured data still returned
        wb_mode = 2; wb_wait = 0; wb_rdata = 32'hCAFE_F00D;
        wb_q.push_back('{32'h0000_0020, 4'h3, 1'b0, 32'h0, 10});
        rsp_q.push_back('{4'hE, 1'b1, 32'hCAFE_F00D, 11});
        run_frame(4'h0, 32'h0000_0020, 4'h3, 32'h0);

        // Write answered with err after two waits
        wb_mode = 1; wb_wait = 2;
        wb_q.push_back('{32'h8000_0004, 4'h6, 1'b1, 32'h0102_0304, 18});
        rsp_q.push_back('{4'hE, 1'b0, 32'h0, 21});
        run_frame(4'h1, 32'h8000_0004, 4'h6, 32'h0102_0304);

        // Frame dropped after the 4th address nibble, then a normal read
        starts = wb_starts;
        send_nibbles(4'h0, 32'h5566_7788, 4'hF, 32'h0, 5, 1'b1);
        idle(4);
        chk("abort_no_wb_cycle", 32'(wb_starts), 32'(starts));
        wb_mode = 0; wb_wait = 1; wb_rdata = 32'h89AB_CDEF;
        wb_q.push_back('{32'h0000_0044, 4'h5, 1'b0, 32'h0, 10});
        rsp_q.push_back('{4'hA, 1'b1, 32'h89AB_CDEF, 12});
        run_frame(4'h0, 32'h0000_0044, 4'h5, 32'h0);

        // Bad header
        starts = wb_starts;
        rsp_q.push_back('{4'hE, 1'b0, 32'h0, -1});
        run_frame(4'h3, 32'hABCD_0000, 4'hF, 32'h0);
        chk("badhdr_no_wb_cycle", 32'(wb_starts), 32'(starts));

        // Async reset in the middle of a bus cycle
        wb_mode = 3; wb_wait = 0;
        wb_q.push_back('{32'h0000_0300, 4'hF, 1'b0, 32'h0, 10});
        send_nibbles(4'h0, 32'h0000_0300, 4'hF, 32'h0, 10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_cyc", 32'(bus.wb_cyc_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cyc_stb", {30'h0, bus.wb_cyc_o, bus.wb_stb_o}, 32'h0);
        chk("async_rst_adr", bus.wb_adr_o, 32'h0);
        chk("async_rst_gic_dat", 32'(bus.gic_dat_o), 32'h0);
        bus.gic_cs_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Slave that never answers
        wb_mode = 3; wb_wait = 0; wb_rdata = 32'h0BAD_C0DE;
        wb_q.push_back('{32'h0000_0400, 4'hF, 1'b0, 32'h0, 10});
`ifdef GIC_SLAVE_TIMEOUT_EN
        rsp_q.push_back('{4'hE, 1'b1, 32'h0, 10 + int'(TmoCycles)});
        run_frame(4'h0, 32'h0000_0400, 4'hF, 32'h0);
        chk("timeout_cyc_len", 32'(last_len), 32'(TmoCycles));
`else
        rsp_q.push_back('{4'hA, 1'b1, 32'h0BAD_C0DE, -1});
        send_nibbles(4'h0, 32'h0000_0400, 4'hF, 32'h0, 10, 1'b0);
        hi = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.wb_cyc_o) hi++;
        end
        chk("cyc_held_1000", 32'(hi), 32'd1000);
        wb_mode = 0;
        rsp_target++;
        wait_rsp(rsp_target);
        idle(2);
`endif

        repeat (3) @(posedge clk);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
        chk("wb_queue_drained", 32'(wb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/gic_slave.md
# gic_slave

Remote end of the Gris InterConnect (GIC) link. Consumes the 4-bit nibble stream and chip select produced by `gic_master`, decodes one single-beat Wishbone transaction per frame, executes it as a Wishbone B3 classic master on the local bus, and returns a status nibble plus read data on the return nibble lane. It sits on the far side of the board-level GIC wires, feeding the local wishbone intercon.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: Wishbone cycles to wait for ack/err before forcing an error status. Used only when `GIC_SLAVE_TIMEOUT_EN` is defined; range 1..65535.

Ports:
- `wb_clk_i`  in  1  system clock. GIC link and Wishbone both run on this clock.
- `wb_rstn_i`  in  1  reset, asynchronous assert, active-low.
- `gic_cs_i`  in  1  frame select from master.
- `gic_dat_i`  in  4  master→slave nibble, sampled every cycle while `gic_cs_i`=1.
- `gic_dat_o`  out  4  slave→master nibble.
- `wb_adr_o`  out  32  Wishbone address.
- `wb_dat_o`  out  32  write data.
- `wb_sel_o`  out  4  byte selects.
- `wb_we_o`  out  1  write enable.
- `wb_cyc_o`  out  1  cycle.
- `wb_stb_o`  out  1  strobe.
- `wb_cti_o`  out  3  always 3'b000 (classic).
- `wb_bte_o`  out  2  always 2'b00.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`  in  1  acknowledge.
- `wb_err_i`  in  1  error.

## Operation
- Frame, nibbles in order, one per cycle while `gic_cs_i`=1: HDR (bit0=we, bits3:1 must be 0), ADR×8 (MSB nibble first), SEL×1, WDAT×8 (MSB first, writes only).
- HDR with bits3:1≠0: no bus cycle; status 4'hE returned; no read data.
- FSM: IDLE → HDR → ADR → SEL → (WDAT if we) → BUS → STAT → (RDAT if !we) → DONE → IDLE.
- IDLE: rising `gic_cs_i` sample is the HDR nibble (HDR captured in the same cycle `gic_cs_i` first seen high).
- BUS: `wb_cyc_o`=`wb_stb_o`=1 with captured adr/sel/we/dat until `wb_ack_i` or `wb_err_i` sampled high; both drop the following cycle. ack and err simultaneous: err wins.
- STAT: one cycle, `gic_dat_o`=4'hA (ack) or 4'hE (err/timeout/bad header).
- RDAT: 8 cycles of the captured `wb_dat_i`, MSB nibble first. Driven even on error status (value then undefined content = captured bus data).
- DONE: `gic_dat_o`=0, extra input nibbles ignored; return to IDLE when `gic_cs_i`=0.
- `gic_dat_o`=4'h0 in every state except STAT/RDAT; 4'h0 is the "wait" code the master polls on.
- `gic_cs_i` falls before BUS: frame discarded, return to IDLE, no bus cycle.
- `gic_cs_i` falls during BUS: current Wishbone cycle runs to ack/err (or timeout), response discarded, IDLE.
- `gic_cs_i` falls during STAT/RDAT: outputs 0 next cycle, IDLE.
- At least one `gic_cs_i`=0 cycle required between frames.

## Timing
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Request length: 10 cycles (read), 18 cycles (write) from first `gic_cs_i` high.
- `wb_cyc_o`/`wb_stb_o` rise the cycle after the last request nibble is sampled.
- STAT is driven in the cycle after ack/err is sampled; RDAT follows immediately.
- Zero-wait slave read: first HDR at cycle 0, cyc/stb at cycle 10, ack at 10, STAT at 11, RDAT 12–19.
- Reset assertion mid-frame or mid-bus cycle: all outputs 0 immediately (async), FSM IDLE.

## Configuration
- `GIC_SLAVE_TIMEOUT_EN` defined: 16-bit counter clears on BUS entry, increments each BUS cycle without ack/err; reaching `TIMEOUT_CYCLES` drops cyc/stb and forces status 4'hE (read data 0).
- Not defined: no counter; BUS waits indefinitely for ack/err; `TIMEOUT_CYCLES` unused.

## Test plan
- Write frame HDR=1, ADR=0x9100_0010, SEL=0xF, WDAT=0xDEADBEEF, zero-wait ack → one Wishbone cycle with those values, `wb_we_o`=1, STAT 4'hA at cycle 19.
- Read frame ADR=0x0000_0100, SEL=0xF, slave returns 0x1234_5678 after 3 wait cycles → STAT 4'hA then nibbles 1,2,3,4,5,6,7,8.
- Read with `wb_err_i` and `wb_ack_i` asserted together → STAT 4'hE.
- `gic_cs_i` dropped after 4th ADR nibble → no `wb_cyc_o`; next full read frame completes normally.
- HDR=4'h3 (bad) → no bus cycle, STAT 4'hE, no RDAT.
- With `GIC_SLAVE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, slave never acks → cyc drops after 16 cycles, STAT 4'hE, read data 0x00000000; without macro, cyc held high for 1000 cycles.
